// File: rtl/dmem_arbiter.sv
// Shares the single-cycle data memory between the core LSU (port 0) and debug/loader (port 1).
// Clears memory after reset; optional DMEM_ARB_FIXED_PRI_EN makes port 0 always win contention.
module dmem_arbiter #(
   parameter int BITSIZE        = 32,
   parameter int ADDR_W         = 6,
   parameter int DEPTH          = 64,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               r0_valid,
   input  logic               r0_we,
   input  logic [ADDR_W-1:0]  r0_addr,
   input  logic [BITSIZE-1:0] r0_wdata,
   output logic               r0_ready,
   output logic               r0_rvalid,
   output logic [BITSIZE-1:0] r0_rdata,
   input  logic               r1_valid,
   input  logic               r1_we,
   input  logic [ADDR_W-1:0]  r1_addr,
   input  logic [BITSIZE-1:0] r1_wdata,
   output logic               r1_ready,
   output logic               r1_rvalid,
   output logic [BITSIZE-1:0] r1_rdata,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic [BITSIZE-1:0] mem_wdata,
   output logic               mem_write,
   output logic               mem_read,
   input  logic [BITSIZE-1:0] mem_rdata,
   output logic               busy,
   output logic               dbg_state,
   output logic               dbg_last_grant
);

   typedef enum logic {ST_CLEAR = 1'b1, ST_ARB = 1'b0} state_t;

   state_t            state;
   logic [ADDR_W-1:0] clr_cnt;
   logic              last_grant;
   logic              gnt0;
   logic              gnt1;

   assign busy           = (state == ST_CLEAR);
   assign dbg_state      = state;
   assign dbg_last_grant = last_grant;

   // Handshake: a transfer happens when valid & ready at posedge; ready is the
   // same-cycle grant, and requesters hold valid/we/addr/wdata stable until it.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (rst && state == ST_ARB) begin
         if (r0_valid && r1_valid) begin
`ifdef DMEM_ARB_FIXED_PRI_EN
            gnt0 = 1'b1;
`else
            gnt0 = last_grant;
            gnt1 = ~last_grant;
`endif
         end else begin
            gnt0 = r0_valid;
            gnt1 = r1_valid;
         end
      end
   end

   assign r0_ready = gnt0;
   assign r1_ready = gnt1;

   always_comb begin
      mem_addr  = '0;
      mem_wdata = '0;
      mem_write = 1'b0;
      mem_read  = 1'b0;
      if (rst) begin
         if (state == ST_CLEAR) begin
            mem_addr  = clr_cnt;
            mem_write = 1'b1;
         end else if (gnt0) begin
            mem_addr  = r0_addr;
            mem_wdata = r0_wdata;
            mem_write = r0_we;
            mem_read  = ~r0_we;
         end else if (gnt1) begin
            mem_addr  = r1_addr;
            mem_wdata = r1_wdata;
            mem_write = r1_we;
            mem_read  = ~r1_we;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= CLEAR_ON_RESET ? ST_CLEAR : ST_ARB;
         clr_cnt    <= '0;
         last_grant <= 1'b1;
         r0_rvalid  <= 1'b0;
         r0_rdata   <= '0;
         r1_rvalid  <= 1'b0;
         r1_rdata   <= '0;
      end else begin
         case (state)
            ST_CLEAR: begin
               r0_rvalid <= 1'b0;
               r1_rvalid <= 1'b0;
               if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
                  clr_cnt <= '0;
                  state   <= ST_ARB;
               end else begin
                  clr_cnt <= clr_cnt + 1'b1;
               end
            end
            default: begin
               r0_rvalid <= gnt0 & ~r0_we;
               r1_rvalid <= gnt1 & ~r1_we;
               if (gnt0 && !r0_we) r0_rdata <= mem_rdata;
               if (gnt1 && !r1_we) r1_rdata <= mem_rdata;
               if (gnt0)      last_grant <= 1'b0;
               else if (gnt1) last_grant <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a 64x32 async-read/sync-write memory model attached.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_FIXED_PRI_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        r0_valid, r0_we, r0_ready, r0_rvalid;
   logic [5:0]  r0_addr;
   logic [31:0] r0_wdata, r0_rdata;
   logic        r1_valid, r1_we, r1_ready, r1_rvalid;
   logic [5:0]  r1_addr;
   logic [31:0] r1_wdata, r1_rdata;
   logic [5:0]  mem_addr;
   logic [31:0] mem_wdata, mem_rdata;
   logic        mem_write, mem_read, busy, dbg_state, dbg_last_grant;

   logic [31:0] mem [64];
   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   always_ff @(posedge clk) if (mem_write) mem[mem_addr] <= mem_wdata;
   assign mem_rdata = mem[mem_addr];

   dmem_arbiter dut (
      .clk(clk), .rst(rst),
      .r0_valid(r0_valid), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
      .r0_ready(r0_ready), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
      .r1_valid(r1_valid), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
      .r1_ready(r1_ready), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
      .mem_read(mem_read), .mem_rdata(mem_rdata), .busy(busy),
      .dbg_state(dbg_state), .dbg_last_grant(dbg_last_grant)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive0(input logic v, input logic we, input logic [5:0] a, input logic [31:0] d);
      r0_valid = v; r0_we = we; r0_addr = a; r0_wdata = d;
   endtask

   task automatic drive1(input logic v, input logic we, input logic [5:0] a, input logic [31:0] d);
      r1_valid = v; r1_we = we; r1_addr = a; r1_wdata = d;
   endtask

   task automatic check_clear_cycle(input int k);
      chk("clr_busy", 32'(busy), 32'd1);
      chk("clr_r0_ready", 32'(r0_ready), 32'd0);
      chk("clr_mem_write", 32'(mem_write), 32'd1);
      chk("clr_mem_read", 32'(mem_read), 32'd0);
      chk("clr_mem_addr", 32'(mem_addr), 32'(k));
      chk("clr_mem_wdata", mem_wdata, 32'd0);
   endtask

   initial begin
      rst = 1'b0;
      drive0(1'b1, 1'b0, 6'd0, 32'd0);
      drive1(1'b0, 1'b0, 6'd0, 32'd0);
      cyc();
      cyc();
      // reset state
      chk("rst_busy", 32'(busy), 32'd1);
      chk("rst_r0_ready", 32'(r0_ready), 32'd0);
      chk("rst_mem_write", 32'(mem_write), 32'd0);
      chk("rst_r0_rvalid", 32'(r0_rvalid), 32'd0);
      chk("rst_r0_rdata", r0_rdata, 32'd0);
      chk("rst_last_grant", 32'(dbg_last_grant), 32'd1);

      // clear sweep with r0 request pending throughout
      rst = 1'b1;
      #1;
      for (int k = 0; k < 64; k++) begin
         check_clear_cycle(k);
         cyc();
      end
      chk("arb_busy", 32'(busy), 32'd0);
      chk("arb_first_r0_ready", 32'(r0_ready), 32'd1);
      chk("arb_first_mem_read", 32'(mem_read), 32'd1);
      cyc();
      chk("cleared_rvalid", 32'(r0_rvalid), 32'd1);
      chk("cleared_rdata", r0_rdata, 32'd0);

      // port 0 write then read of addr 5
      drive0(1'b1, 1'b1, 6'd5, 32'hDEADBEEF);
      #1;
      chk("wr5_ready", 32'(r0_ready), 32'd1);
      chk("wr5_mem_write", 32'(mem_write), 32'd1);
      chk("wr5_mem_read", 32'(mem_read), 32'd0);
      chk("wr5_mem_addr", 32'(mem_addr), 32'd5);
      chk("wr5_mem_wdata", mem_wdata, 32'hDEADBEEF);
      cyc();
      chk("wr5_no_rvalid", 32'(r0_rvalid), 32'd0);
      chk("wr5_rdata_hold", r0_rdata, 32'd0);
      drive0(1'b1, 1'b0, 6'd5, 32'd0);
      #1;
      chk("rd5_mem_read", 32'(mem_read), 32'd1);
      chk("rd5_mem_write", 32'(mem_write), 32'd0);
      cyc();
      chk("rd5_rvalid", 32'(r0_rvalid), 32'd1);
      chk("rd5_rdata", r0_rdata, 32'hDEADBEEF);
      chk("rd5_last_grant", 32'(dbg_last_grant), 32'd0);

      // preload 0x11 at addr 1 (port 0) and 0x22 at addr 2 (port 1)
      drive0(1'b1, 1'b1, 6'd1, 32'h11);
      cyc();
      drive0(1'b0, 1'b0, 6'd0, 32'd0);
      drive1(1'b1, 1'b1, 6'd2, 32'h22);
      #1;
      chk("pre_r1_ready", 32'(r1_ready), 32'd1);
      cyc();
      chk("pre_last_grant", 32'(dbg_last_grant), 32'd1);

      // continuous contention: grants alternate starting with port 0
      drive0(1'b1, 1'b0, 6'd1, 32'd0);
      drive1(1'b1, 1'b0, 6'd2, 32'd0);
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("rr_r0_ready", 32'(r0_ready), (FIXED || i % 2 == 0) ? 32'd1 : 32'd0);
         chk("rr_r1_ready", 32'(r1_ready), (!FIXED && i % 2 == 1) ? 32'd1 : 32'd0);
         cyc();
         chk("rr_r0_rvalid", 32'(r0_rvalid), (FIXED || i % 2 == 0) ? 32'd1 : 32'd0);
         chk("rr_r1_rvalid", 32'(r1_rvalid), (!FIXED && i % 2 == 1) ? 32'd1 : 32'd0);
         chk("rr_r0_rdata", r0_rdata, 32'h11);
         if (!FIXED && i % 2 == 1) chk("rr_r1_rdata", r1_rdata, 32'h22);
      end

      // idle arbitration
      drive0(1'b0, 1'b0, 6'd0, 32'd0);
      drive1(1'b0, 1'b0, 6'd0, 32'd0);
      for (int i = 0; i < 2; i++) begin
         #1;
         chk("idle_mem_read", 32'(mem_read), 32'd0);
         chk("idle_mem_write", 32'(mem_write), 32'd0);
         chk("idle_mem_addr", 32'(mem_addr), 32'd0);
         cyc();
         chk("idle_r0_rvalid", 32'(r0_rvalid), 32'd0);
         chk("idle_r1_rvalid", 32'(r1_rvalid), 32'd0);
         chk("idle_last_grant", 32'(dbg_last_grant), FIXED ? 32'd0 : 32'd1);
      end

      // r1 writes addr 63, r0 reads it the next cycle
      drive1(1'b1, 1'b1, 6'd63, 32'hA5A5A5A5);
      cyc();
      chk("w63_r1_no_rvalid", 32'(r1_rvalid), 32'd0);
      drive1(1'b0, 1'b0, 6'd0, 32'd0);
      drive0(1'b1, 1'b0, 6'd63, 32'd0);
      #1;
      chk("r63_ready", 32'(r0_ready), 32'd1);
      cyc();
      chk("r63_rvalid", 32'(r0_rvalid), 32'd1);
      chk("r63_rdata", r0_rdata, 32'hA5A5A5A5);

      // reset mid-ARB drops the in-flight rvalid
      rst = 1'b0;
      #1;
      chk("arst_busy", 32'(busy), 32'd1);
      chk("arst_r0_rvalid", 32'(r0_rvalid), 32'd0);
      chk("arst_r0_rdata", r0_rdata, 32'd0);
      chk("arst_r0_ready", 32'(r0_ready), 32'd0);
      cyc();
      rst = 1'b1;
      #1;
      for (int k = 0; k < 20; k++) begin
         check_clear_cycle(k);
         cyc();
      end
      chk("mid_clr_addr20", 32'(mem_addr), 32'd20);

      // reset mid-CLEAR restarts the sweep from address 0
      rst = 1'b0;
      #1;
      chk("crst_busy", 32'(busy), 32'd1);
      chk("crst_r0_rvalid", 32'(r0_rvalid), 32'd0);
      chk("crst_mem_write", 32'(mem_write), 32'd0);
      chk("crst_r0_ready", 32'(r0_ready), 32'd0);
      cyc();
      rst = 1'b1;
      #1;
      for (int k = 0; k < 64; k++) begin
         check_clear_cycle(k);
         cyc();
      end
      chk("reclr_busy", 32'(busy), 32'd0);
      chk("reclr_r0_ready", 32'(r0_ready), 32'd1);
      chk("reclr_mem_addr", 32'(mem_addr), 32'd63);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
